decimal_entry_12bits: RTL and testbench



---
 rtl/decimal_entry_12bits_if.sv | 25 ++
 rtl/decimal_entry_12bits.sv | 135 +++++++++++++
 tb/tb_decimal_entry_12bits.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decimal_entry_12bits_if.sv
// Keypad-style decimal entry bus: digit/enter/clear strobes in, running and committed values out.
interface decimal_entry_12bits_if;
  logic [3:0]  i_digit;
  logic        i_digit_stb;
  logic        i_enter;
  logic        i_clr;
  logic [11:0] o_value;
  logic [15:0] o_bcd;
  logic [2:0]  o_count;
  logic        o_busy;
  logic [11:0] o_result;
  logic        o_valid;
  logic        o_ovf;
  logic        o_err;

  modport master (
    output i_digit, i_digit_stb, i_enter, i_clr,
    input  o_value, o_bcd, o_count, o_busy, o_result, o_valid, o_ovf, o_err
  );

  modport slave (
    input  i_digit, i_digit_stb, i_enter, i_clr,
    output o_value, o_bcd, o_count, o_busy, o_result, o_valid, o_ovf, o_err
  );
endinterface

// File: rtl/decimal_entry_12bits.sv
// Accumulates BCD digits into a saturating 12-bit binary value; ENTER commits, CLR discards.
module decimal_entry_12bits #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_VALUE  = 4095
) (
  input logic                    i_clk,
  input logic                    i_rst,
  decimal_entry_12bits_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

  localparam logic [13:0] MaxAcc = 14'(MAX_VALUE);
  localparam logic [11:0] MaxVal = 12'(MAX_VALUE);
  localparam logic [2:0]  MaxCnt = 3'(MAX_DIGITS);

  state_e      r_state, w_state_d;
  logic [13:0] r_acc, w_acc_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [15:0] r_bcd, w_bcd_d;
  logic [3:0]  r_digit, w_digit_d;
  logic        w_err_d, w_commit, w_clear;

  logic [11:0] r_value, r_result;
  logic [15:0] r_bcd_o;
  logic [2:0]  r_cnt_o;
  logic        r_ovf, r_valid, r_err, r_busy;

  logic [17:0] w_mul;
  logic [13:0] w_acc_calc;
  logic [11:0] w_sat;

  // acc*10 + digit via shifts; clamp keeps larger MAX_DIGITS from wrapping
  assign w_mul      = (18'(r_acc) << 3) + (18'(r_acc) << 1) + 18'(r_digit);
  assign w_acc_calc = (w_mul > 18'h3FFF) ? 14'h3FFF : w_mul[13:0];
  assign w_sat      = (r_acc > MaxAcc) ? MaxVal : r_acc[11:0];
  assign w_clear    = io_bus.i_clr | w_commit;

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_bcd_d   = r_bcd;
    w_digit_d = r_digit;
    w_err_d   = 1'b0;
    w_commit  = 1'b0;
    if (io_bus.i_clr) begin
      w_state_d = StIdle;
      w_acc_d   = '0;
      w_cnt_d   = '0;
      w_bcd_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.i_enter) begin
            w_state_d = StCommit;
          end else if (io_bus.i_digit_stb) begin
            if (io_bus.i_digit <= 4'd9 && r_cnt < MaxCnt) begin
              w_digit_d = io_bus.i_digit;
              w_state_d = StCalc;
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        StCalc: begin
          w_acc_d   = w_acc_calc;
          w_cnt_d   = r_cnt + 3'd1;
          w_bcd_d   = {r_bcd[11:0], r_digit};
          w_state_d = StIdle;
        end
        StCommit: begin
          w_commit  = 1'b1;
          w_acc_d   = '0;
          w_cnt_d   = '0;
          w_bcd_d   = '0;
          w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_digit  <= '0;
      r_value  <= '0;
      r_bcd_o  <= '0;
      r_cnt_o  <= '0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_bcd   <= w_bcd_d;
      r_digit <= w_digit_d;
      r_err   <= w_err_d;
      r_valid <= w_commit;
      r_busy  <= (w_state_d == StCalc);
      // Output stage trails the accumulator by one edge, except clears land at once
      if (w_clear) begin
        r_value <= '0;
        r_bcd_o <= '0;
        r_cnt_o <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_value <= w_sat;
        r_bcd_o <= r_bcd;
        r_cnt_o <= r_cnt;
        r_ovf   <= r_ovf | (r_acc > MaxAcc);
      end
      if (w_commit) begin
        r_result <= w_sat;
      end
    end
  end

  assign io_bus.o_value  = r_value;
  assign io_bus.o_bcd    = r_bcd_o;
  assign io_bus.o_count  = r_cnt_o;
  assign io_bus.o_busy   = r_busy;
  assign io_bus.o_result = r_result;
  assign io_bus.o_valid  = r_valid;
  assign io_bus.o_ovf    = r_ovf;
  assign io_bus.o_err    = r_err;

endmodule

// File: tb/tb_decimal_entry_12bits.sv
// Randomized and directed checks of decimal_entry_12bits against a digit-list reference model.
module tb_decimal_entry_12bits;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decimal_entry_12bits_if bus ();

  decimal_entry_12bits #(
    .MAX_DIGITS(4),
    .MAX_VALUE (4095)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the list of accepted digits, last committed result, sticky overflow
  int q[$];
  int m_result = 0;
  bit m_ovf    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_raw();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic int m_value();
    int v = m_raw();
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic int m_bcd();
    int b = 0;
    foreach (q[i]) b = ((b << 4) | q[i]) & 32'hFFFF;
    return b;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".value"},  32'(bus.o_value),  m_value());
    check_eq({tag, ".bcd"},    32'(bus.o_bcd),    m_bcd());
    check_eq({tag, ".count"},  32'(bus.o_count),  q.size());
    check_eq({tag, ".ovf"},    32'(bus.o_ovf),    32'(m_ovf));
    check_eq({tag, ".result"}, 32'(bus.o_result), m_result);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".value"},  32'(bus.o_value),  0);
    check_eq({tag, ".bcd"},    32'(bus.o_bcd),    0);
    check_eq({tag, ".count"},  32'(bus.o_count),  0);
    check_eq({tag, ".result"}, 32'(bus.o_result), 0);
    check_eq({tag, ".flags"},
             32'({bus.o_valid, bus.o_err, bus.o_ovf, bus.o_busy}), 0);
  endtask

  // One operation: drive for one cycle, then watch the three following cycles
  task automatic op(input string tag, input bit clr, input bit ent, input bit stb, input int d);
    bit e_err = 1'b0, e_busy = 1'b0, e_valid = 1'b0;
    int cnt_mid;
    @(negedge clk);
    bus.i_clr       = clr;
    bus.i_enter     = ent;
    bus.i_digit_stb = stb;
    bus.i_digit     = 4'(d);
    cnt_mid = q.size();
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      cnt_mid = 0;
    end else if (ent) begin
      m_result = m_value();
      e_valid  = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      cnt_mid = 0;
    end else if (stb) begin
      if (d > 9 || q.size() >= 4) begin
        e_err = 1'b1;
      end else begin
        q.push_back(d);
        e_busy = 1'b1;
        if (m_raw() > 4095) m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    bus.i_clr = 1'b0; bus.i_enter = 1'b0; bus.i_digit_stb = 1'b0;
    check_eq({tag, ".err1"},   32'(bus.o_err),   32'(e_err));
    check_eq({tag, ".busy1"},  32'(bus.o_busy),  32'(e_busy));
    check_eq({tag, ".valid1"}, 32'(bus.o_valid), 0);
    @(negedge clk);
    check_eq({tag, ".valid2"}, 32'(bus.o_valid), 32'(e_valid));
    check_eq({tag, ".err2"},   32'(bus.o_err),   0);
    check_eq({tag, ".count2"}, 32'(bus.o_count), cnt_mid);
    @(negedge clk);
    check_eq({tag, ".valid3"}, 32'(bus.o_valid), 0);
    check_eq({tag, ".busy3"},  32'(bus.o_busy),  0);
    check_state(tag);
  endtask

  initial begin
    bus.i_digit = '0; bus.i_digit_stb = 1'b0; bus.i_enter = 1'b0; bus.i_clr = 1'b0;
    #1;
    check_zero("reset_init");
    @(posedge clk); #2 rst = 1'b0;

    op("d1", 0, 0, 1, 1);
    op("d6", 0, 0, 1, 6);
    op("d9", 0, 0, 1, 9);
    op("d8", 0, 0, 1, 8);
    check_eq("r034.value", 32'(bus.o_value), 1698);
    check_eq("r034.bcd",   32'(bus.o_bcd),   32'h1698);
    op("rej5th", 0, 0, 1, 3);
    op("ent1698", 0, 1, 0, 0);
    check_eq("r034.result", 32'(bus.o_result), 1698);

    op("rejA", 0, 0, 1, 10);
    op("ent0", 0, 1, 0, 0);

    op("o5", 0, 0, 1, 5);
    op("o0a", 0, 0, 1, 0);
    op("o0b", 0, 0, 1, 0);
    op("o0c", 0, 0, 1, 0);
    check_eq("r035.value", 32'(bus.o_value), 4095);
    check_eq("r035.ovf",   32'(bus.o_ovf),   1);
    op("ent4095", 0, 1, 0, 0);

    op("c2", 0, 0, 1, 2);
    op("c5", 0, 0, 1, 5);
    op("clr_stb", 1, 0, 1, 7);
    check_eq("r037.result", 32'(bus.o_result), 4095);

    // Strobe and ENTER while busy are ignored
    @(negedge clk);
    bus.i_digit_stb = 1'b1; bus.i_digit = 4'd9;
    q.push_back(9);
    @(negedge clk);
    check_eq("r038.busy", 32'(bus.o_busy), 1);
    bus.i_digit = 4'd4; bus.i_enter = 1'b1;
    @(negedge clk);
    bus.i_digit_stb = 1'b0; bus.i_enter = 1'b0;
    check_eq("r038.err1", 32'({bus.o_err, bus.o_valid}), 0);
    @(negedge clk);
    check_eq("r038.err2", 32'({bus.o_err, bus.o_valid}), 0);
    check_state("r038");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    bus.i_digit_stb = 1'b1; bus.i_digit = 4'd3;
    @(posedge clk); #3;
    bus.i_digit_stb = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    q.delete(); m_result = 0; m_ovf = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    op("post_rst", 0, 0, 1, 4);

    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 99);
      bit clr = (r < 8);
      bit ent = (r >= 8 && r < 22);
      bit stb = (r < 4) || (r >= 16);
      int d = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      op("rnd", clr, ent, stb, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
